riscv_dm_axil_sri_bridge: RTL
=============================

Name: riscv_dm_axil_sri_bridge

Overview:
AXI4-Lite slave to SRI master bridge that gives the system bus access to the Debug Module program buffer and data memory. It sits directly upstream of the Debug Module wrapper and drives its sri_* inputs. It runs on the DM core clock. It performs one SRI access per AXI transaction and returns the SRI error flag as the AXI response.

Parameters:
AXI_ADDR_WIDTH, 20, AXI byte address width; must be >= SRI_ADDR_WIDTH.
SRI_ADDR_WIDTH, 6, SRI address width in bytes (MEMORY_SEL_BITS+BYTE_SEL_BITS of the DM).
DATA_WIDTH, 64, AXI and SRI data width; both sides are fixed equal.

Ports:
clk_i  in  1  core clock
rst_i  in  1  synchronous active-high reset
s_awvalid_i/s_awready_o  in/out  1  write address handshake
s_awaddr_i  in  AXI_ADDR_WIDTH  write byte address
s_wvalid_i/s_wready_o  in/out  1  write data handshake
s_wdata_i  in  DATA_WIDTH  write data
s_wstrb_i  in  DATA_WIDTH/8  byte strobes
s_bvalid_o/s_bready_i  out/in  1  write response handshake
s_bresp_o  out  2  00 OKAY, 10 SLVERR
s_arvalid_i/s_arready_o  in/out  1  read address handshake
s_araddr_i  in  AXI_ADDR_WIDTH  read byte address
s_rvalid_o/s_rready_i  out/in  1  read data handshake
s_rdata_o  out  DATA_WIDTH  read data
s_rresp_o  out  2  00 OKAY, 10 SLVERR
sri_addr_o  out  SRI_ADDR_WIDTH  SRI address
sri_en_o  out  1  SRI access strobe, one cycle per access
sri_we_o  out  1  1 = write
sri_wdata_o  out  DATA_WIDTH  SRI write data
sri_be_o  out  DATA_WIDTH/8  SRI byte enables
sri_rdata_i  in  DATA_WIDTH  SRI read data, valid the cycle after sri_en_o
sri_error_i  in  1  SRI error, valid the cycle after sri_en_o, for reads and writes

Behaviour:
- Clock and reset: one clock, clk_i. rst_i is synchronous and active-high.
- Reset clears all holding registers, state goes to IDLE, and all outputs go to 0, except ready outputs, which follow the rules below.
- An in-flight transaction is dropped on reset; no B or R response is ever issued for it.
- Holding registers: AW, W and AR are each captured independently, each with its own full flag.
  - s_awready_o = !aw_full, s_wready_o = !w_full, s_arready_o = !ar_full, all combinational from registered flags.
  - AW and W may arrive in any order or in the same cycle.
  - A full flag clears on the edge of its response handshake (B for AW/W, R for AR). The next request is accepted no earlier than the following cycle.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE: a write is eligible when aw_full && w_full; a read is eligible when ar_full.
  - IDLE, both eligible: grant the type not granted last. The first grant after reset goes to the read.
  - IDLE, a single eligible type: grant it.
  - IDLE, AW captured without W (or W without AW): not eligible; wait.
  - ISSUE, one cycle: sri_en_o=1, sri_we_o=write, sri_addr_o=addr[SRI_ADDR_WIDTH-1:0].
    - Upper address bits are ignored; the SRI space aliases.
    - Writes: sri_wdata_o=wdata, sri_be_o=wstrb. wstrb=0 is still issued.
    - Reads: sri_be_o all ones, sri_wdata_o=0.
  - ISSUE outputs: sri_en_o is 0 in every other state. Address/data/be hold their last value outside ISSUE.
  - WAIT, one cycle: capture sri_error_i into resp = {error,1'b0}. For reads, also capture sri_rdata_i.
  - RESP: assert s_bvalid_o (write) or s_rvalid_o (read), with resp and data stable until the handshake.
    - On handshake: clear the relevant full flags, return to IDLE.
    - s_rdata_o is 0 for writes; it holds the captured value while rvalid=1.
- Latency: handshake completing in cycle 0 → IDLE sees full in cycle 1 → sri_en_o in cycle 2 → WAIT in cycle 3 → valid response in cycle 4 (with ready held high).
- Throughput: at most one transaction in flight. Minimum 5 cycles per transaction back-to-back.
- Backpressure: while RESP waits on bready/rready, no SRI access is issued. New requests of the other type may still be captured if their holding register is empty.

Test Plan:
- Write: AW addr 0x08 and W data 0xDEADBEEF_CAFEF00D, strb 0xFF, same cycle 0 → sri_en_o=1, we=1, addr=0x08, be=0xFF in cycle 2. With sri_error_i=0 in cycle 3 → bvalid in cycle 4, bresp=00.
- Read: AR addr 0x10 in cycle 0; sri_rdata_i=0x1234_5678_9ABC_DEF0 in cycle 3 → rvalid in cycle 4, rdata=that value, rresp=00. Hold rready=0 for 3 cycles → rvalid/rdata stable and sri_en_o stays 0.
- Error: read and write accesses with sri_error_i=1 in WAIT → rresp=10 and bresp=10 respectively.
- Ordering and arbitration:
  - W arrives 3 cycles before AW → no SRI access until both are captured; then a single access with the W data.
  - AW+W and AR presented simultaneously after reset → read issued first, then write.
  - Next simultaneous pair → read and write alternate.
- Reset and aliasing:
  - Assert rst_i in cycle 3 of a read → no rvalid ever; all ready outputs = 1 the cycle after reset deasserts; sri_en_o=0.
  - awaddr 0xF_FF08 with SRI_ADDR_WIDTH=6 → sri_addr_o=0x08.

Source files
------------

// File: rtl/riscv_dm_axil_sri_bridge.sv
// AXI4-Lite slave to SRI master bridge feeding the Debug Module program buffer / data memory.
// One SRI access per AXI transaction; the SRI error flag is returned as SLVERR.
module riscv_dm_axil_sri_bridge #(
  parameter int AXI_ADDR_WIDTH = 20,
  parameter int SRI_ADDR_WIDTH = 6,
  parameter int DATA_WIDTH     = 64
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      s_awvalid_i,
  output logic                      s_awready_o,
  input  logic [AXI_ADDR_WIDTH-1:0] s_awaddr_i,
  input  logic                      s_wvalid_i,
  output logic                      s_wready_o,
  input  logic [DATA_WIDTH-1:0]     s_wdata_i,
  input  logic [DATA_WIDTH/8-1:0]   s_wstrb_i,
  output logic                      s_bvalid_o,
  input  logic                      s_bready_i,
  output logic [1:0]                s_bresp_o,
  input  logic                      s_arvalid_i,
  output logic                      s_arready_o,
  input  logic [AXI_ADDR_WIDTH-1:0] s_araddr_i,
  output logic                      s_rvalid_o,
  input  logic                      s_rready_i,
  output logic [DATA_WIDTH-1:0]     s_rdata_o,
  output logic [1:0]                s_rresp_o,
  output logic [SRI_ADDR_WIDTH-1:0] sri_addr_o,
  output logic                      sri_en_o,
  output logic                      sri_we_o,
  output logic [DATA_WIDTH-1:0]     sri_wdata_o,
  output logic [DATA_WIDTH/8-1:0]   sri_be_o,
  input  logic [DATA_WIDTH-1:0]     sri_rdata_i,
  input  logic                      sri_error_i
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  state_e                    state_q, state_d;
  logic                      aw_full_q, aw_full_d;
  logic [SRI_ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
  logic                      w_full_q, w_full_d;
  logic [DATA_WIDTH-1:0]     w_data_q, w_data_d;
  logic [STRB_WIDTH-1:0]     w_strb_q, w_strb_d;
  logic                      ar_full_q, ar_full_d;
  logic [SRI_ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d;
  logic                      is_write_q, is_write_d;
  logic                      last_write_q, last_write_d;
  logic                      sri_en_q, sri_en_d;
  logic                      sri_we_q, sri_we_d;
  logic [SRI_ADDR_WIDTH-1:0] sri_addr_q, sri_addr_d;
  logic [DATA_WIDTH-1:0]     sri_wdata_q, sri_wdata_d;
  logic [STRB_WIDTH-1:0]     sri_be_q, sri_be_d;
  logic [1:0]                resp_q, resp_d;
  logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
  logic                      bvalid_q, bvalid_d;
  logic                      rvalid_q, rvalid_d;

  logic write_ok_s;
  logic read_ok_s;
  logic grant_write_s;

  // The SRI space aliases, so upper AXI address bits are intentionally dropped.
  generate
    if (AXI_ADDR_WIDTH > SRI_ADDR_WIDTH) begin : g_addr_fold
      logic unused_addr_s;
      assign unused_addr_s = ^{s_awaddr_i[AXI_ADDR_WIDTH-1:SRI_ADDR_WIDTH],
                               s_araddr_i[AXI_ADDR_WIDTH-1:SRI_ADDR_WIDTH]};
    end
  endgenerate

  assign write_ok_s    = aw_full_q & w_full_q;
  assign read_ok_s     = ar_full_q;
  // On a tie the type not granted last wins; last_write resets to 1 so the first tie goes to the read.
  assign grant_write_s = write_ok_s & (~read_ok_s | ~last_write_q);

  assign s_awready_o = ~aw_full_q;
  assign s_wready_o  = ~w_full_q;
  assign s_arready_o = ~ar_full_q;
  assign s_bvalid_o  = bvalid_q;
  assign s_bresp_o   = is_write_q ? resp_q : 2'b00;
  assign s_rvalid_o  = rvalid_q;
  assign s_rresp_o   = is_write_q ? 2'b00 : resp_q;
  assign s_rdata_o   = rdata_q;
  assign sri_en_o    = sri_en_q;
  assign sri_we_o    = sri_we_q;
  assign sri_addr_o  = sri_addr_q;
  assign sri_wdata_o = sri_wdata_q;
  assign sri_be_o    = sri_be_q;

  always_comb begin
    state_d      = state_q;
    aw_full_d    = aw_full_q;
    aw_addr_d    = aw_addr_q;
    w_full_d     = w_full_q;
    w_data_d     = w_data_q;
    w_strb_d     = w_strb_q;
    ar_full_d    = ar_full_q;
    ar_addr_d    = ar_addr_q;
    is_write_d   = is_write_q;
    last_write_d = last_write_q;
    sri_en_d     = 1'b0;
    sri_we_d     = sri_we_q;
    sri_addr_d   = sri_addr_q;
    sri_wdata_d  = sri_wdata_q;
    sri_be_d     = sri_be_q;
    resp_d       = resp_q;
    rdata_d      = rdata_q;
    bvalid_d     = bvalid_q;
    rvalid_d     = rvalid_q;

    if (s_awvalid_i && !aw_full_q) begin
      aw_full_d = 1'b1;
      aw_addr_d = s_awaddr_i[SRI_ADDR_WIDTH-1:0];
    end else begin
      aw_addr_d = aw_addr_q;
    end
    if (s_wvalid_i && !w_full_q) begin
      w_full_d = 1'b1;
      w_data_d = s_wdata_i;
      w_strb_d = s_wstrb_i;
    end else begin
      w_data_d = w_data_q;
    end
    if (s_arvalid_i && !ar_full_q) begin
      ar_full_d = 1'b1;
      ar_addr_d = s_araddr_i[SRI_ADDR_WIDTH-1:0];
    end else begin
      ar_addr_d = ar_addr_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (write_ok_s || read_ok_s) begin
          state_d      = ST_ISSUE;
          is_write_d   = grant_write_s;
          last_write_d = grant_write_s;
          sri_en_d     = 1'b1;
          sri_we_d     = grant_write_s;
          if (grant_write_s) begin
            sri_addr_d  = aw_addr_q;
            sri_wdata_d = w_data_q;
            sri_be_d    = w_strb_q;
          end else begin
            sri_addr_d  = ar_addr_q;
            sri_wdata_d = {DATA_WIDTH{1'b0}};
            sri_be_d    = {STRB_WIDTH{1'b1}};
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        state_d = ST_RESP;
        resp_d  = {sri_error_i, 1'b0};
        if (is_write_q) begin
          rdata_d  = {DATA_WIDTH{1'b0}};
          bvalid_d = 1'b1;
        end else begin
          rdata_d  = sri_rdata_i;
          rvalid_d = 1'b1;
        end
      end
      ST_RESP: begin
        if (is_write_q && s_bready_i) begin
          bvalid_d  = 1'b0;
          aw_full_d = 1'b0;
          w_full_d  = 1'b0;
          state_d   = ST_IDLE;
        end else if (!is_write_q && s_rready_i) begin
          rvalid_d  = 1'b0;
          ar_full_d = 1'b0;
          state_d   = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Reset drops any in-flight transaction so no late B/R response can appear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      aw_full_q    <= 1'b0;
      aw_addr_q    <= {SRI_ADDR_WIDTH{1'b0}};
      w_full_q     <= 1'b0;
      w_data_q     <= {DATA_WIDTH{1'b0}};
      w_strb_q     <= {STRB_WIDTH{1'b0}};
      ar_full_q    <= 1'b0;
      ar_addr_q    <= {SRI_ADDR_WIDTH{1'b0}};
      is_write_q   <= 1'b0;
      last_write_q <= 1'b1;
      sri_en_q     <= 1'b0;
      sri_we_q     <= 1'b0;
      sri_addr_q   <= {SRI_ADDR_WIDTH{1'b0}};
      sri_wdata_q  <= {DATA_WIDTH{1'b0}};
      sri_be_q     <= {STRB_WIDTH{1'b0}};
      resp_q       <= 2'b00;
      rdata_q      <= {DATA_WIDTH{1'b0}};
      bvalid_q     <= 1'b0;
      rvalid_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      aw_full_q    <= aw_full_d;
      aw_addr_q    <= aw_addr_d;
      w_full_q     <= w_full_d;
      w_data_q     <= w_data_d;
      w_strb_q     <= w_strb_d;
      ar_full_q    <= ar_full_d;
      ar_addr_q    <= ar_addr_d;
      is_write_q   <= is_write_d;
      last_write_q <= last_write_d;
      sri_en_q     <= sri_en_d;
      sri_we_q     <= sri_we_d;
      sri_addr_q   <= sri_addr_d;
      sri_wdata_q  <= sri_wdata_d;
      sri_be_q     <= sri_be_d;
      resp_q       <= resp_d;
      rdata_q      <= rdata_d;
      bvalid_q     <= bvalid_d;
      rvalid_q     <= rvalid_d;
    end
  end

endmodule
